// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor computing a - b - b_in, one bit per clock,
// LSB first, through a single gate-level full-subtractor cell and a registered borrow.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   start  request, sampled only while idle
//   a, b   minuend / subtrahend, sampled on the accepting edge
//   b_in   borrow-in, sampled on the accepting edge
//   busy   high while bits are being processed
//   done   one-cycle pulse: diff and b_out hold a fresh result
//   diff   difference, holds the last result
//   b_out  final borrow-out, holds the last result
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             br;
  logic [CntW-1:0]  cnt;

  logic a0, b0;
  logic cell_d, cell_br;
  logic last;
  logic accept;

  assign a0 = a_sh[0];
  assign b0 = b_sh[0];

  // Full-subtractor cell in AND/OR/NOT form; the XOR is expanded as a sum of products.
  assign cell_d  = (~a0 & ~b0 &  br) | (~a0 &  b0 & ~br) |
                   ( a0 & ~b0 & ~br) | ( a0 &  b0 &  br);
  assign cell_br = (~a0 & b0) | (~a0 & br) | (b0 & br);

  assign last   = (cnt == CntLast);
  assign accept = (state_q == StIdle) && start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      b_out <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      r_sh <= '0;
      br   <= b_in;
      cnt  <= '0;
    end else if (state_q == StRun) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= {cell_d, r_sh[WIDTH-1:1]};
      br   <= cell_br;
      cnt  <= cnt + CntW'(1);
      // The outputs take the fully shifted result, including the bit produced on this edge.
      if (last) begin
        diff  <= {cell_d, r_sh[WIDTH-1:1]};
        b_out <= cell_br;
      end
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule
